// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host-to-device transmitter.
// The frame is start + 8 data (LSB first) + odd parity + stop, then an ACK edge.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        INHIBIT = 2'd1,
        START   = 2'd2,
        FRAME   = 2'd3
    } ps2_state_e;

    localparam int unsigned FRAME_EDGES = 11;
    localparam int unsigned STOP_EDGE   = 10;
    localparam int unsigned EDGE_W      = $clog2(FRAME_EDGES + 1);

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for one PS/2 pin plus a falling-edge strobe.
// All flops reset to 1 (idle line level) so reset release never looks like an edge.
module ps2_line_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic line_i,
    output logic sync_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= line_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign sync_o = sync_q;
    assign fall_o = prev_q & ~sync_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host transmitter: inhibit KCLK, request-to-send, shift one byte on device
// clock falls, then check the device ACK. *_OE=1 pulls the open-drain pin low.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned TIMEOUT_CYCLES = 750000
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [7:0] TX_DATA,
    input  logic       TX_START,
    output logic       TX_BUSY,
    output logic       TX_DONE,
    output logic       TX_ERR,
    input  logic       KCLK_IN,
    input  logic       KDATA_IN,
    output logic       KCLK_OE,
    output logic       KDATA_OE
);

    localparam int unsigned INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
    localparam int unsigned WD_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [INH_W-1:0]  INH_LAST  = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [WD_W-1:0]   WD_LAST   = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(FRAME_EDGES);
    localparam logic [EDGE_W-1:0] STOP_E    = EDGE_W'(STOP_EDGE);

    ps2_state_e        state_q, state_d;
    logic [INH_W-1:0]  inh_q, inh_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic [EDGE_W-1:0] edge_q, edge_d;
    logic [EDGE_W-1:0] edge_nxt;
    logic [9:0]        frame_q, frame_d;
    logic              kclk_oe_q, kclk_oe_d;
    logic              kdata_oe_q, kdata_oe_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic kclk_fall;
    logic kclk_sync_unused;
    logic kdata_sync;
    logic kdata_fall_unused;

    ps2_line_sync u_kclk_sync (
        .clk_i  (CLK),
        .rst_ni (RST_N),
        .line_i (KCLK_IN),
        .sync_o (kclk_sync_unused),
        .fall_o (kclk_fall)
    );

    ps2_line_sync u_kdata_sync (
        .clk_i  (CLK),
        .rst_ni (RST_N),
        .line_i (KDATA_IN),
        .sync_o (kdata_sync),
        .fall_o (kdata_fall_unused)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= IDLE;
            inh_q      <= '0;
            wd_q       <= '0;
            edge_q     <= '0;
            frame_q    <= '0;
            kclk_oe_q  <= 1'b0;
            kdata_oe_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            inh_q      <= inh_d;
            wd_q       <= wd_d;
            edge_q     <= edge_d;
            frame_q    <= frame_d;
            kclk_oe_q  <= kclk_oe_d;
            kdata_oe_q <= kdata_oe_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    // frame_q holds the bits still to be put on KDATA, stop bit in the MSB;
    // the start bit is driven directly on leaving INHIBIT.
    always_comb begin
        state_d    = state_q;
        inh_d      = inh_q;
        wd_d       = wd_q;
        edge_d     = edge_q;
        frame_d    = frame_q;
        kclk_oe_d  = kclk_oe_q;
        kdata_oe_d = kdata_oe_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        edge_nxt   = edge_q + 1'b1;

        case (state_q)
            IDLE: begin
                kclk_oe_d  = 1'b0;
                kdata_oe_d = 1'b0;
                if (TX_START) begin
                    frame_d   = {1'b1, odd_parity(TX_DATA), TX_DATA};
                    inh_d     = '0;
                    kclk_oe_d = 1'b1;
                    state_d   = INHIBIT;
                end
            end

            INHIBIT: begin
                if (inh_q == INH_LAST) begin
                    kdata_oe_d = 1'b1;
                    state_d    = START;
                end else begin
                    inh_d = inh_q + 1'b1;
                end
            end

            START: begin
                kclk_oe_d = 1'b0;
                edge_d    = '0;
                wd_d      = '0;
                state_d   = FRAME;
            end

            FRAME: begin
                wd_d = wd_q + 1'b1;
                // The ACK edge wins over a watchdog expiry in the same cycle.
                if (kclk_fall && (edge_nxt == LAST_EDGE)) begin
                    done_d     = ~kdata_sync;
                    err_d      = kdata_sync;
                    kdata_oe_d = 1'b0;
                    edge_d     = '0;
                    wd_d       = '0;
                    state_d    = IDLE;
                end else if (wd_q == WD_LAST) begin
                    err_d      = 1'b1;
                    kdata_oe_d = 1'b0;
                    edge_d     = '0;
                    wd_d       = '0;
                    state_d    = IDLE;
                end else if (kclk_fall) begin
                    edge_d = edge_nxt;
                    if (edge_nxt <= STOP_E) begin
                        kdata_oe_d = ~frame_q[0];
                        frame_d    = {1'b1, frame_q[9:1]};
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign TX_BUSY  = (state_q != IDLE);
    assign TX_DONE  = done_q;
    assign TX_ERR   = err_q;
    assign KCLK_OE  = kclk_oe_q;
    assign KDATA_OE = kdata_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-drain PS/2 device model and a
// cycle-level expectation model of the host outputs.
module tb_ps2_host_tx;

    localparam int INH  = 8;
    localparam int TMO  = 2000;
    localparam int HALF = 20;
    localparam int W    = 34;

    localparam logic [1:0] KIND_DONE = 2'd1;
    localparam logic [1:0] KIND_ERR  = 2'd2;

    logic       CLK      = 1'b0;
    logic       RST_N    = 1'b1;
    logic [7:0] TX_DATA  = 8'h00;
    logic       TX_START = 1'b0;
    logic       TX_BUSY;
    logic       TX_DONE;
    logic       TX_ERR;
    logic       KCLK_OE;
    logic       KDATA_OE;
    logic       KCLK_IN;
    logic       KDATA_IN;

    logic dev_clk  = 1'b1;
    logic dev_data = 1'b1;

    // Open-drain wiring: the line is high unless either side pulls it low.
    assign KCLK_IN  = dev_clk & ~KCLK_OE;
    assign KDATA_IN = dev_data & ~KDATA_OE;

    int cyc       = 0;
    int checks    = 0;
    int passes    = 0;
    int done_seen = 0;
    int err_seen  = 0;

    // Expected result pulses: {kind, cycle}.
    logic [W-1:0] exp_q[$];

    logic in_txn     = 1'b0;
    logic end_known  = 1'b0;
    int   busy_start = 0;
    int   end_cyc    = 0;

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .TX_DATA  (TX_DATA),
        .TX_START (TX_START),
        .TX_BUSY  (TX_BUSY),
        .TX_DONE  (TX_DONE),
        .TX_ERR   (TX_ERR),
        .KCLK_IN  (KCLK_IN),
        .KDATA_IN (KDATA_IN),
        .KCLK_OE  (KCLK_OE),
        .KDATA_OE (KDATA_OE)
    );

    // ---------------- clock / reset ----------------
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation ran past its time limit at cycle %0d", cyc);
        $fatal(1);
    end

    // ---------------- model ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic model_busy(input int c);
        return in_txn && (c >= busy_start) && (!end_known || (c < end_cyc));
    endfunction

    // Line levels the device should see: start 0, data LSB first, odd parity, stop 1.
    function automatic logic [10:0] model_frame(input logic [7:0] d);
        logic par;
        par = (($countones(d) % 2) == 0);
        return {1'b1, par, d, 1'b0};
    endfunction

    // ---------------- compare process ----------------
    always @(negedge CLK) begin
        if (!RST_N) begin
            check("reset_outputs", {TX_BUSY, TX_DONE, TX_ERR, KCLK_OE, KDATA_OE}, 5'b0);
        end else begin
            logic       pulse_now;
            logic [1:0] kind;
            logic       mb;
            int         rel;
            pulse_now = (exp_q.size() > 0) && (int'(exp_q[0][31:0]) == cyc);
            kind      = pulse_now ? exp_q[0][33:32] : 2'b00;
            if (pulse_now) void'(exp_q.pop_front());
            mb  = model_busy(cyc);
            rel = cyc - busy_start;
            check("done_pulse", TX_DONE, kind == KIND_DONE);
            check("err_pulse", TX_ERR, kind == KIND_ERR);
            check("busy", TX_BUSY, mb);
            check("kclk_oe", KCLK_OE, mb && (rel <= INH));
            if (!mb || rel < INH) check("kdata_oe", KDATA_OE, 1'b0);
            else if (rel == INH)  check("kdata_oe_start", KDATA_OE, 1'b1);
        end
    end

    always @(negedge CLK) begin
        if (TX_DONE === 1'b1) done_seen++;
        if (TX_ERR === 1'b1)  err_seen++;
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [7:0] d, input logic expect_timeout);
        logic accepted;
        @(posedge CLK); #1;
        TX_DATA  = d;
        TX_START = 1'b1;
        accepted = !model_busy(cyc);
        @(posedge CLK); #1;
        TX_START = 1'b0;
        if (accepted) begin
            in_txn     = 1'b1;
            busy_start = cyc;
            end_known  = 1'b0;
            if (expect_timeout) begin
                end_known = 1'b1;
                end_cyc   = busy_start + INH + 1 + TMO;
                exp_q.push_back({KIND_ERR, 32'(end_cyc)});
            end
        end
    endtask

    // Device side: waits for request-to-send, then clocks n_edges falls at a
    // 2*HALF period, sampling KDATA on each rise; drives ack_val before edge 11.
    task automatic device_frame(input int n_edges, input logic ack_val, output logic [10:0] got);
        int guard;
        got   = '0;
        guard = 0;
        while (!(KCLK_OE == 1'b0 && KDATA_OE == 1'b1 && TX_BUSY == 1'b1) && guard < 200) begin
            @(negedge CLK);
            guard++;
        end
        if (guard >= 200) begin
            check("req_to_send_seen", {KCLK_OE, KDATA_OE}, 2'b01);
            return;
        end
        repeat (HALF) @(posedge CLK);
        #1;
        got[0] = KDATA_IN;
        for (int k = 1; k <= n_edges; k++) begin
            dev_clk = 1'b0;
            if (k == 11) begin
                end_known = 1'b1;
                end_cyc   = cyc + 3;
                exp_q.push_back({(ack_val ? KIND_ERR : KIND_DONE), 32'(end_cyc)});
            end
            repeat (HALF) @(posedge CLK);
            #1;
            dev_clk = 1'b1;
            if (k <= 10) got[k] = KDATA_IN;
            if (k == 10) dev_data = ack_val;
            repeat (HALF) @(posedge CLK);
            #1;
        end
        dev_data = 1'b1;
    endtask

    task automatic wait_result(input string name);
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 2200) begin
            @(negedge CLK);
            guard++;
        end
        check({name, "_result_due"}, exp_q.size(), 0);
        repeat (4) @(negedge CLK);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [10:0] got;
        int d0;
        int e0;

        #1 RST_N = 1'b0;
        repeat (3) @(negedge CLK);
        check("rst_busy", TX_BUSY, 1'b0);
        check("rst_done", TX_DONE, 1'b0);
        check("rst_err", TX_ERR, 1'b0);
        check("rst_kclk_oe", KCLK_OE, 1'b0);
        check("rst_kdata_oe", KDATA_OE, 1'b0);
        RST_N = 1'b1;
        repeat (3) @(negedge CLK);

        // 0xED acknowledged
        d0 = done_seen; e0 = err_seen;
        send(8'hED, 1'b0);
        device_frame(11, 1'b0, got);
        check("ed_frame_model", got, model_frame(8'hED));
        check("ed_frame_lit", got, 11'h7DA);
        wait_result("ed");
        check("ed_done_count", done_seen - d0, 1);
        check("ed_err_count", err_seen - e0, 0);

        // 0x01 acknowledged
        d0 = done_seen; e0 = err_seen;
        send(8'h01, 1'b0);
        device_frame(11, 1'b0, got);
        check("x01_frame_model", got, model_frame(8'h01));
        check("x01_frame_lit", got, 11'h402);
        wait_result("x01");
        check("x01_done_count", done_seen - d0, 1);

        // No ACK from the device
        d0 = done_seen; e0 = err_seen;
        send(8'h55, 1'b0);
        device_frame(11, 1'b1, got);
        check("noack_frame_model", got, model_frame(8'h55));
        check("noack_frame_lit", got, 11'h6AA);
        wait_result("noack");
        check("noack_err_count", err_seen - e0, 1);
        check("noack_done_count", done_seen - d0, 0);
        check("noack_oe_after", {KCLK_OE, KDATA_OE}, 2'b00);

        // Device never clocks: watchdog
        d0 = done_seen; e0 = err_seen;
        send(8'hA5, 1'b1);
        wait_result("timeout");
        check("timeout_err_count", err_seen - e0, 1);
        check("timeout_done_count", done_seen - d0, 0);

        // Start request and data change while busy
        d0 = done_seen; e0 = err_seen;
        send(8'hF4, 1'b0);
        fork
            device_frame(11, 1'b0, got);
            begin
                repeat (150) @(posedge CLK);
                send(8'hAA, 1'b0);
            end
        join
        check("busy_frame_model", got, model_frame(8'hF4));
        check("busy_frame_lit", got, 11'h5E8);
        wait_result("busy");
        check("busy_done_count", done_seen - d0, 1);
        check("busy_err_count", err_seen - e0, 0);

        // Reset after edge 5, then a clean 0xFF
        send(8'hFF, 1'b0);
        device_frame(5, 1'b1, got);
        check("midrst_busy_before", TX_BUSY, 1'b1);
        @(negedge CLK);
        #2;
        RST_N  = 1'b0;
        in_txn = 1'b0;
        exp_q.delete();
        #1;
        check("midrst_busy", TX_BUSY, 1'b0);
        check("midrst_done", TX_DONE, 1'b0);
        check("midrst_err", TX_ERR, 1'b0);
        check("midrst_kclk_oe", KCLK_OE, 1'b0);
        check("midrst_kdata_oe", KDATA_OE, 1'b0);
        repeat (3) @(negedge CLK);
        RST_N = 1'b1;
        repeat (5) @(negedge CLK);
        d0 = done_seen; e0 = err_seen;
        send(8'hFF, 1'b0);
        device_frame(11, 1'b0, got);
        check("ff_frame_model", got, model_frame(8'hFF));
        check("ff_frame_lit", got, 11'h7FE);
        wait_result("ff");
        check("ff_done_count", done_seen - d0, 1);
        check("ff_err_count", err_seen - e0, 0);

        check("exp_queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
